rbm_visible_sampler: RTL and testbench
======================================

Name: rbm_visible_sampler

Overview:
Reverse (hidden-to-visible) half of the RBM Gibbs step. Takes a latched hidden-layer state vector and computes each visible unit's activation, bias_j + sum_i h_i*W[i][j], sequentially on one shared accumulator. It squashes the activation through a piecewise-linear sigmoid and samples a binary visible state against an on-chip LFSR. The reconstructed visible vector is returned over a valid/ready handshake to the Gibbs sequencer.

Parameters:
N_HID, 4, number of hidden units (input vector width)
N_VIS, 4, number of visible units (output vector width)
W_W, 16, weight/bias width, signed Q(W_W-8).8
ACC_W, 20, accumulator width, signed Q(ACC_W-8).8; must be >= W_W+clog2(N_HID+1)
LFSR_SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  request a reconstruction; sampled only in IDLE
hidden  in  N_HID  hidden state vector, latched on accepted start
w_we  in  1  weight write enable
w_addr_i  in  clog2(N_HID)  weight row (hidden index)
w_addr_j  in  clog2(N_VIS)  weight column (visible index)
w_data  in  W_W  weight value, signed Q.8
b_we  in  1  bias write enable
b_addr  in  clog2(N_VIS)  bias index
b_data  in  W_W  bias value, signed Q.8
busy  out  1  high from accepted start until the output handshake completes
out_valid  out  1  visible vector available
out_ready  in  1  consumer accepts visible vector
visible  out  N_VIS  sampled visible states

Behaviour:
- Reset: state IDLE; busy=0, out_valid=0, visible=0. All weights, all biases and acc clear to 0; LFSR loads the seed. Reset while busy aborts the run with no out_valid pulse.
- Writes: w_we/b_we take effect at the clock edge only when busy=0 and they are ignored while busy=1. W is indexed [i][j].
- IDLE: start=1 latches hidden into hq and sets j=0, i=0, acc=sext(bias[0]). Next state ACC, busy=1.
- ACC (N_HID cycles): acc += hq[i] ? sext(W[i][j]) : 0; i++. After i=N_HID-1 the next state is SAMPLE.
- SAMPLE (1 cycle):
  - p_raw = 128 + (acc >>> 2), signed, giving 0.5 + x/4 in 1/256 units.
  - If p_raw >= 256, v=1. If p_raw <= 0, v=0. Otherwise v = (lfsr[7:0] < p_raw[7:0]).
  - visible_q[j] <= v. The LFSR advances exactly one step, and only in this state.
  - If j = N_VIS-1, go to OUT. Otherwise j++, i=0, acc=sext(bias[j+1]), and return to ACC.
- OUT: out_valid=1 and visible=visible_q, both held stable until out_ready=1. On out_valid&&out_ready, go to IDLE with out_valid=0 and busy=0 in the next cycle. visible retains its last value afterwards.
- Latency: out_valid rises N_VIS*(N_HID+1)+1 cycles after the start edge (21 at defaults). Throughput is one vector per latency plus the handshake.
- start while busy (including in OUT) is ignored, not queued. start and out_ready in the same OUT cycle: the handshake completes and start is ignored.
- LFSR: 16-bit Galois, right-shift, polynomial mask 16'hB400; never reaches zero.
- Accumulator cannot overflow given the ACC_W constraint, so no saturation is applied before the sigmoid.

Decomposition:
- Package rbm_pkg: FRAC_BITS=8, SIG_HALF=128, SIG_SHIFT=2, LFSR_TAPS=16'hB400, state enum {IDLE, ACC, SAMPLE, OUT}, and a helper function for the sigmoid sample decision.
- Sub-module rbm_lfsr16: clk, rst, step, seed parameter, 16-bit state out. The same module is reused by the forward Boltzmann node.

Test Plan:
1. Reset, then start with hidden=4'b1111 and all weights/biases 0 -> acc=0, p_raw=128 on every unit. visible matches the reference model run from seed 16'hACE1, and out_valid rises exactly 21 cycles after start.
2. All W=16'h0400 (+4.0), bias 0, hidden=1111 -> acc=4096, p_raw saturates, visible=4'b1111. All W=16'hFC00 (-4.0) -> visible=4'b0000.
3. hidden=0000, bias[2]=+8.0, other biases -8.0 -> visible=4'b0100 for 8 consecutive runs; the LFSR advances 4 steps per run.
4. out_ready held 0 for 10 cycles after out_valid -> visible and out_valid stable, a start pulse during the wait is ignored, busy stays 1. Raising out_ready -> IDLE next cycle.
5. rst asserted 7 cycles into a run -> out_valid is never asserted. A new start then reproduces test 1 exactly (LFSR reseeded).
6. Write W[1][3]=+8.0 while busy -> no effect on that run or later runs. The same write while idle, with hidden=0010 and bias 0 -> visible[3]=1.

Source files
------------

// File: rtl/rbm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rbm_pkg
// Description : Shared constants, FSM state type and sigmoid sampling helper
//               for the RBM Gibbs-step datapaths.
// Revision    : 1.0 - initial release
// ============================================================================
package rbm_pkg;

    localparam int          FRAC_BITS = 8;
    localparam int          SIG_HALF  = 128;
    localparam int          SIG_SHIFT = 2;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC    = 2'd1,
        SAMPLE = 2'd2,
        OUT    = 2'd3
    } state_t;

    // Piecewise-linear sigmoid p = 0.5 + x/4 (in 1/256 units), clamped to
    // [0,1], then a Bernoulli draw using the low byte of the LFSR.
    function automatic logic sigmoid_sample(input logic signed [31:0] acc,
                                            input logic [15:0]        rnd);
        logic signed [31:0] p_raw;
        p_raw = 32'(SIG_HALF) + (acc >>> SIG_SHIFT);
        if (p_raw >= 32'sd256) begin
            return 1'b1;
        end else if (p_raw <= 32'sd0) begin
            return 1'b0;
        end else begin
            return (rnd[7:0] < p_raw[7:0]);
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/rbm_lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : rbm_lfsr16
// Description : 16-bit right-shifting Galois LFSR, one step per asserted
//               'step'. A zero seed is replaced by 1 so it never locks up.
// Revision    : 1.0 - initial release
// ============================================================================
module rbm_lfsr16
    import rbm_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    output logic [15:0] state
);

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] state_d;
    logic [15:0] state_q;

    // Next-state: shift right, fold taps back in when a one falls out.
    always_comb begin
        state_d = state_q;
        if (step) begin
            state_d = (state_q >> 1) ^ (state_q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    // State register, reloads the seed on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED_EFF;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule
`default_nettype wire

// File: rtl/rbm_visible_sampler.sv
`default_nettype none
// ============================================================================
// Module      : rbm_visible_sampler
// Description : Hidden-to-visible half of an RBM Gibbs step. One shared
//               accumulator computes bias_j + sum_i h_i*W[i][j] per visible
//               unit, squashes it through a linear sigmoid and samples a
//               binary state against an LFSR. Result leaves on valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module rbm_visible_sampler
    import rbm_pkg::*;
#(
    parameter int          N_HID     = 4,
    parameter int          N_VIS     = 4,
    parameter int          W_W       = 16,
    parameter int          ACC_W     = 20,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    input  logic [N_HID-1:0]                             hidden,
    input  logic                                         w_we,
    input  logic [((N_HID > 1) ? $clog2(N_HID) : 1)-1:0] w_addr_i,
    input  logic [((N_VIS > 1) ? $clog2(N_VIS) : 1)-1:0] w_addr_j,
    input  logic [W_W-1:0]                               w_data,
    input  logic                                         b_we,
    input  logic [((N_VIS > 1) ? $clog2(N_VIS) : 1)-1:0] b_addr,
    input  logic [W_W-1:0]                               b_data,
    output logic                                         busy,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [N_VIS-1:0]                             visible
);

    localparam int HI_W = (N_HID > 1) ? $clog2(N_HID) : 1;
    localparam int VJ_W = (N_VIS > 1) ? $clog2(N_VIS) : 1;
    localparam logic [HI_W-1:0] I_LAST = HI_W'(N_HID - 1);
    localparam logic [VJ_W-1:0] J_LAST = VJ_W'(N_VIS - 1);

    // Sign-extend a Q.8 weight/bias into the accumulator format.
    function automatic logic signed [ACC_W-1:0] sext_w(input logic signed [W_W-1:0] v);
        return ACC_W'(v);
    endfunction

    state_t                  state_q,     state_d;
    logic                    busy_q,      busy_d;
    logic                    out_valid_q, out_valid_d;
    logic [N_VIS-1:0]        visible_q,   visible_d;
    logic [N_VIS-1:0]        vis_work_q,  vis_work_d;
    logic [N_HID-1:0]        hq_q,        hq_d;
    logic [HI_W-1:0]         i_q,         i_d;
    logic [VJ_W-1:0]         j_q,         j_d;
    logic signed [ACC_W-1:0] acc_q,       acc_d;
    logic signed [W_W-1:0]   w_q [N_HID][N_VIS];
    logic signed [W_W-1:0]   w_d [N_HID][N_VIS];
    logic signed [W_W-1:0]   b_q [N_VIS];
    logic signed [W_W-1:0]   b_d [N_VIS];

    logic [15:0]     lfsr_state;
    logic            lfsr_step;
    logic            sample_bit;
    logic [VJ_W-1:0] j_next;

    // The LFSR only moves while a unit is being sampled, so each run
    // consumes exactly N_VIS steps.
    assign lfsr_step  = (state_q == SAMPLE);
    assign sample_bit = sigmoid_sample(32'(acc_q), lfsr_state);
    assign j_next     = j_q + VJ_W'(1);

    rbm_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .step  (lfsr_step),
        .state (lfsr_state)
    );

    // Next-state logic: parameter writes while idle, FSM sequencing and
    // the shared multiply-free accumulate (hidden bits are binary).
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        visible_d   = visible_q;
        vis_work_d  = vis_work_q;
        hq_d        = hq_q;
        i_d         = i_q;
        j_d         = j_q;
        acc_d       = acc_q;
        w_d         = w_q;
        b_d         = b_q;

        // Parameter memory is frozen for the duration of a run.
        if (!busy_q) begin
            if (w_we) begin
                w_d[w_addr_i][w_addr_j] = w_data;
            end
            if (b_we) begin
                b_d[b_addr] = b_data;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    hq_d    = hidden;
                    i_d     = '0;
                    j_d     = '0;
                    acc_d   = sext_w(b_q[0]);
                    busy_d  = 1'b1;
                    state_d = ACC;
                end
            end
            ACC: begin
                if (hq_q[i_q]) begin
                    acc_d = acc_q + sext_w(w_q[i_q][j_q]);
                end
                if (i_q == I_LAST) begin
                    state_d = SAMPLE;
                end else begin
                    i_d = i_q + HI_W'(1);
                end
            end
            SAMPLE: begin
                vis_work_d[j_q] = sample_bit;
                if (j_q == J_LAST) begin
                    state_d = OUT;
                end else begin
                    j_d     = j_next;
                    i_d     = '0;
                    acc_d   = sext_w(b_q[j_next]);
                    state_d = ACC;
                end
            end
            OUT: begin
                // First OUT cycle publishes the vector; afterwards hold
                // it until the consumer takes it.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    visible_d   = vis_work_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any run in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            visible_q   <= '0;
            vis_work_q  <= '0;
            hq_q        <= '0;
            i_q         <= '0;
            j_q         <= '0;
            acc_q       <= '0;
            w_q         <= '{default: '0};
            b_q         <= '{default: '0};
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            visible_q   <= visible_d;
            vis_work_q  <= vis_work_d;
            hq_q        <= hq_d;
            i_q         <= i_d;
            j_q         <= j_d;
            acc_q       <= acc_d;
            w_q         <= w_d;
            b_q         <= b_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign visible   = visible_q;

endmodule
`default_nettype wire

// File: tb/tb_rbm_visible_sampler.sv
`default_nettype none
// ============================================================================
// Module      : tb_rbm_visible_sampler
// Description : Self-checking bench for rbm_visible_sampler against an
//               arithmetic reference model of the Gibbs reconstruction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rbm_visible_sampler;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  hidden;
    logic        w_we;
    logic [1:0]  w_addr_i;
    logic [1:0]  w_addr_j;
    logic [15:0] w_data;
    logic        b_we;
    logic [1:0]  b_addr;
    logic [15:0] b_data;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  visible;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          mw [4][4];
    int          mb [4];
    logic [15:0] m_lfsr;
    logic [3:0]  t1_vis;

    rbm_visible_sampler #(
        .N_HID     (4),
        .N_VIS     (4),
        .W_W       (16),
        .ACC_W     (20),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .hidden    (hidden),
        .w_we      (w_we),
        .w_addr_i  (w_addr_i),
        .w_addr_j  (w_addr_j),
        .w_data    (w_data),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .visible   (visible)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mb[i] = 0;
            for (int j = 0; j < 4; j++) mw[i][j] = 0;
        end
        m_lfsr = 16'hACE1;
    endtask

    // Expected visible vector for hidden h; consumes four LFSR draws.
    task automatic model_run(input logic [3:0] h, output logic [3:0] vis);
        int sum;
        int p;
        for (int j = 0; j < 4; j++) begin
            sum = mb[j];
            for (int i = 0; i < 4; i++) if (h[i]) sum += mw[i][j];
            p = 128 + (sum >>> 2);
            if (p >= 256)      vis[j] = 1'b1;
            else if (p <= 0)   vis[j] = 1'b0;
            else               vis[j] = (int'(m_lfsr[7:0]) < p);
            m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic write_w(input int i, input int j, input logic [15:0] val);
        w_we = 1'b1; w_addr_i = 2'(i); w_addr_j = 2'(j); w_data = val;
        @(posedge clk); #1;
        w_we = 1'b0;
        mw[i][j] = int'($signed(val));
    endtask

    task automatic write_b(input int j, input logic [15:0] val);
        b_we = 1'b1; b_addr = 2'(j); b_data = val;
        @(posedge clk); #1;
        b_we = 1'b0;
        mb[j] = int'($signed(val));
    endtask

    // Starts a run and waits (bounded) for out_valid; lat = cycles after start edge.
    task automatic do_run(input logic [3:0] h, output logic [3:0] vis, output int lat);
        start = 1'b1; hidden = h;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        vis = visible;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL handshake_idle: out_valid=%b busy=%b required 0 0", out_valid, busy);
        end
    endtask

    task automatic run_and_check(input string name, input logic [3:0] h, output logic [3:0] vis);
        logic [3:0] exp_v;
        int lat;
        model_run(h, exp_v);
        do_run(h, vis, lat);
        checks++;
        if (lat !== 21) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles required 21", name, lat);
        end
        checks++;
        if (vis !== exp_v) begin
            errors++;
            $display("FAIL %s_visible: got %b required %b", name, vis, exp_v);
        end
        handshake();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || visible !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state: busy=%b out_valid=%b visible=%b required 0 0 0000",
                     busy, out_valid, visible);
        end
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_zero_weights();
        run_and_check("zero_w", 4'b1111, t1_vis);
    endtask

    task automatic test_saturation();
        logic [3:0] v;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) write_w(i, j, 16'h0400);
        run_and_check("sat_pos", 4'b1111, v);
        checks++;
        if (v !== 4'b1111) begin
            errors++;
            $display("FAIL sat_pos_const: got %b required 1111", v);
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) write_w(i, j, 16'hFC00);
        run_and_check("sat_neg", 4'b1111, v);
        checks++;
        if (v !== 4'b0000) begin
            errors++;
            $display("FAIL sat_neg_const: got %b required 0000", v);
        end
    endtask

    task automatic test_bias_only();
        logic [3:0] v;
        for (int j = 0; j < 4; j++) write_b(j, (j == 2) ? 16'h0800 : 16'hF800);
        for (int r = 0; r < 8; r++) begin
            run_and_check("bias", 4'b0000, v);
            checks++;
            if (v !== 4'b0100) begin
                errors++;
                $display("FAIL bias_const run %0d: got %b required 0100", r, v);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] exp_v;
        logic [3:0] v;
        int lat;
        model_run(4'b1010, exp_v);
        do_run(4'b1010, v, lat);
        checks++;
        if (v !== exp_v || lat !== 21) begin
            errors++;
            $display("FAIL bp_first: visible=%b lat=%0d required %b 21", v, lat, exp_v);
        end
        for (int k = 0; k < 10; k++) begin
            if (k == 3) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || visible !== v || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: out_valid=%b visible=%b busy=%b required 1 %b 1",
                         k, out_valid, visible, busy, v);
            end
        end
        handshake();
        repeat (4) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL bp_start_ignored: out_valid=%b busy=%b required 0 0", out_valid, busy);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [3:0] v;
        int seen;
        start = 1'b1; hidden = 4'b1111;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid === 1'b1 || busy === 1'b1) seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_valid: active cycles=%0d required 0", seen);
        end
        run_and_check("abort_rerun", 4'b1111, v);
        checks++;
        if (v !== t1_vis) begin
            errors++;
            $display("FAIL abort_repeat: got %b required %b", v, t1_vis);
        end
    endtask

    task automatic test_busy_write();
        logic [3:0] exp_v;
        logic [3:0] v;
        int lat;
        model_run(4'b0010, exp_v);
        start = 1'b1; hidden = 4'b0010;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        w_we = 1'b1; w_addr_i = 2'd1; w_addr_j = 2'd3; w_data = 16'h0800;
        @(posedge clk); #1;
        w_we = 1'b0;
        lat = 3;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (visible !== exp_v || lat !== 21) begin
            errors++;
            $display("FAIL busy_write_run: visible=%b lat=%0d required %b 21", visible, lat, exp_v);
        end
        handshake();
        run_and_check("busy_write_later", 4'b0010, v);
        write_w(1, 3, 16'h0800);
        run_and_check("idle_write", 4'b0010, v);
        checks++;
        if (v[3] !== 1'b1) begin
            errors++;
            $display("FAIL idle_write_bit3: got %b required 1", v[3]);
        end
    endtask

    task automatic test_random();
        logic [3:0] v;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    write_w(i, j, 16'(int'($urandom_range(0, 2047)) - 1024));
            for (int j = 0; j < 4; j++)
                write_b(j, 16'(int'($urandom_range(0, 1023)) - 512));
            run_and_check("random", 4'($urandom_range(0, 15)), v);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; hidden = '0; out_ready = 1'b0;
        w_we = 1'b0; w_addr_i = '0; w_addr_j = '0; w_data = '0;
        b_we = 1'b0; b_addr = '0; b_data = '0;
        test_reset();
        test_zero_weights();
        test_saturation();
        test_bias_only();
        test_backpressure();
        test_reset_abort();
        test_busy_write();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
